// File: rtl/vca_pkg.sv
// Shared types and arithmetic helpers for the multi-channel VCA.
package vca_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSlew,
        StMul,
        StFlush,
        StCommit
    } vca_state_e;

    // Arithmetic right shift by frac, then clamp to the signed range of a w-bit value (w <= 64).
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] prod,
                                                      input int unsigned        frac,
                                                      input int unsigned        w);
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        shifted = prod >>> frac;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (w - 1));
        if (shifted > hi) begin
            res = hi;
        end else if (shifted < lo) begin
            res = lo;
        end else begin
            res = shifted;
        end
        return res;
    endfunction

endpackage

// File: rtl/vca_mac_stage.sv
// Shared gain multiplier: registered product, then shift/saturate feeding the result capture.
module vca_mac_stage
    import vca_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned GAIN_FRAC = 14,
    parameter int unsigned ChW       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [ChW-1:0]      ch_i,
    input  logic signed [W-1:0] gain_i,
    input  logic signed [W-1:0] sample_i,
    output logic                valid_o,
    output logic [ChW-1:0]      ch_o,
    output logic signed [W-1:0] res_o
);

    localparam int unsigned PW = 2 * W;

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic                 valid_q;
    logic [ChW-1:0]       ch_q;
    logic signed [63:0]   sat_full;
    logic                 unused_sat_hi;

    assign prod_d = PW'(gain_i) * PW'(sample_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                prod_q <= prod_d;
                ch_q   <= ch_i;
            end
        end
    end

    assign sat_full      = sat_shift(64'(prod_q), GAIN_FRAC, W);
    assign res_o         = sat_full[W-1:0];
    assign unused_sat_hi = ^sat_full[63:W];
    assign valid_o       = valid_q;
    assign ch_o          = ch_q;

endmodule

// File: rtl/vca_multi.sv
// Multi-channel VCA: channel 0 is the gain CV (passed through), the rest are scaled by the
// rectified, slew-limited CV through one time-multiplexed multiplier.
module vca_multi
    import vca_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned GAIN_FRAC  = 14,
    parameter int unsigned SLEW_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_strobe,
    input  logic [N_CH*W-1:0] sample_in,
    output logic [N_CH*W-1:0] sample_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned          ChW     = $clog2(N_CH);
    localparam int unsigned          WG      = W + 1;
    localparam logic [ChW-1:0]       LastCh  = ChW'(N_CH - 1);
    localparam logic signed [WG-1:0] StepOne = WG'(1);

    vca_state_e state_q, state_d;

    logic [ChW-1:0]       ch_q;
    logic signed [W-1:0]  gain_q, gain_d;
    logic signed [W-1:0]  frame_q  [N_CH];
    logic signed [W-1:0]  result_q [N_CH];
    logic signed [W-1:0]  result_d [N_CH];
    logic [N_CH*W-1:0]    sample_out_q, commit_vec;
    logic                 out_valid_q;
    logic                 accept, mac_in_valid, mac_valid;
    logic [ChW-1:0]       mac_ch;
    logic signed [W-1:0]  mac_res;
    logic signed [WG-1:0] target, diff, step_raw, step;

    assign accept = (state_q == StIdle) && sample_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (sample_strobe) state_d = StSlew;
            StSlew:   state_d = StMul;
            StMul:    if (ch_q == LastCh) state_d = StFlush;
            StFlush:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        overrun      = sample_strobe && busy;
        mac_in_valid = (state_q == StMul);
    end

    // Fall back to a unit step when the shifted error is zero so the gain lands exactly on target.
    always_comb begin
        target   = (frame_q[0] > 0) ? WG'(frame_q[0]) : '0;
        diff     = target - WG'(gain_q);
        step_raw = diff >>> SLEW_SHIFT;
        if (step_raw != '0) begin
            step = step_raw;
        end else if (diff == '0) begin
            step = '0;
        end else begin
            step = diff[WG-1] ? -StepOne : StepOne;
        end
        gain_d = W'(WG'(gain_q) + step);
    end

    always_comb begin
        result_d = result_q;
        if (mac_valid) begin
            result_d[mac_ch] = mac_res;
        end
        commit_vec          = '0;
        commit_vec[W-1:0]   = frame_q[0];
        for (int k = 1; k < N_CH; k++) begin
            commit_vec[k*W +: W] = result_d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= '0;
            gain_q       <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                frame_q[k]  <= '0;
                result_q[k] <= '0;
            end
        end else begin
            result_q    <= result_d;
            out_valid_q <= (state_q == StFlush);
            if (accept) begin
                ch_q <= ChW'(1);
                for (int k = 0; k < N_CH; k++) begin
                    frame_q[k] <= sample_in[k*W +: W];
                end
            end else if (state_q == StMul) begin
                ch_q <= ch_q + ChW'(1);
            end
            if (state_q == StSlew) begin
                gain_q <= gain_d;
            end
            // Last product is captured via result_d in the same edge, so all channels commit at once.
            if (state_q == StFlush) begin
                sample_out_q <= commit_vec;
            end
        end
    end

    vca_mac_stage #(
        .W         (W),
        .GAIN_FRAC (GAIN_FRAC),
        .ChW       (ChW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (mac_in_valid),
        .ch_i     (ch_q),
        .gain_i   (gain_q),
        .sample_i (frame_q[ch_q]),
        .valid_o  (mac_valid),
        .ch_o     (mac_ch),
        .res_o    (mac_res)
    );

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_vca_multi.sv
// Directed bench for vca_multi: two instances (no smoothing / SLEW_SHIFT=4) against a scoreboard.
module tb_vca_multi;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         strobe = 1'b0;
    logic [N*W-1:0] sin  = '0;
    logic [N*W-1:0] out0, out4;
    logic         v0, v4, b0, b4, o0, o4;

    logic [N*W-1:0] q0[$];
    logic [N*W-1:0] q4[$];
    logic [N*W-1:0] last0, last4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g0       = 0;
    int g4       = 0;
    int t_strobe = 0;
    int gi, prev, nv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vca_multi #(.W(W), .N_CH(N), .GAIN_FRAC(14), .SLEW_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_strobe(strobe), .sample_in(sin),
        .sample_out(out0), .out_valid(v0), .busy(b0), .overrun(o0)
    );

    vca_multi #(.W(W), .N_CH(N), .GAIN_FRAC(14), .SLEW_SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sample_strobe(strobe), .sample_in(sin),
        .sample_out(out4), .out_valid(v4), .busy(b4), .overrun(o4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int chv(input logic [N*W-1:0] v, input int k);
        logic signed [W-1:0] s;
        s = v[k*W +: W];
        return int'(s);
    endfunction

    function automatic int slew(input int g, input int cv, input int sh);
        int t, d, s;
        t = (cv > 0) ? cv : 0;
        d = t - g;
        s = d >>> sh;
        if (s == 0) s = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
        return g + s;
    endfunction

    function automatic logic [N*W-1:0] expect_out(input int g, input int cv, input int c1,
                                                  input int c2, input int c3);
        logic [N*W-1:0] r;
        int             x[N];
        longint         p;
        x[0] = cv; x[1] = c1; x[2] = c2; x[3] = c3;
        r[W-1:0] = W'(x[0]);
        for (int k = 1; k < N; k++) begin
            p = (longint'(g) * longint'(x[k])) >>> 14;
            if (p > 32767) p = 32767;
            else if (p < -32768) p = -32768;
            r[k*W +: W] = W'(p);
        end
        return r;
    endfunction

    task automatic send(input int cv, input int c1, input int c2, input int c3);
        @(posedge clk); #1;
        sin    = {W'(c3), W'(c2), W'(c1), W'(cv)};
        strobe = 1'b1;
        g0 = slew(g0, cv, 0);
        g4 = slew(g4, cv, 4);
        q0.push_back(expect_out(g0, cv, c1, c2, c3));
        q4.push_back(expect_out(g4, cv, c1, c2, c3));
        t_strobe = cyc;
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (v0) begin
                seen = 1'b1;
                check({tag, " latency"}, cyc - t_strobe, 6);
                check({tag, " valid4"}, v4, 1'b1);
                check({tag, " queued"}, (q0.size() > 0) && (q4.size() > 0), 1'b1);
                if (q0.size() > 0 && q4.size() > 0) begin
                    check({tag, " out dut0"}, out0, q0.pop_front());
                    check({tag, " out dut4"}, out4, q4.pop_front());
                end
                last0 = out0;
                last4 = out4;
            end
        end
        check({tag, " out_valid seen"}, seen, 1'b1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out dut0", out0, '0);
        check("reset out dut4", out4, '0);
        check("reset flags", {v0, b0, o0, v4, b4, o4}, 6'b0);
        rst_n = 1'b1;

        // Gain slews up from 0; ch1 = unity so out1 reads back the gain directly.
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            send(16384, 16384, -16384, 100);
            wait_out("slew");
            gi = chv(last4, 1);
            if (i == 0) check("slew step1", gi, 1024);
            if (i == 1) check("slew step2", gi, 1984);
            if (i == 2) check("slew step3", gi, 2884);
            check("slew monotonic", gi >= prev, 1'b1);
            prev = gi;
        end
        check("slew converged", gi, 16384);
        check("slew dut0 immediate", chv(last0, 1), 16384);

        // Unity gain pass-through.
        send(16384, 1000, -1000, 0);
        wait_out("unity");
        check("unity ch0", chv(last0, 0), 16384);
        check("unity ch1", chv(last0, 1), 1000);
        check("unity ch2", chv(last0, 2), -1000);
        check("unity ch3", chv(last0, 3), 0);

        // Negative CV rectifies to zero gain.
        for (int i = 0; i < 3; i++) begin
            send(-5000, 20000, -7, 3);
            wait_out("negcv");
        end
        check("negcv ch0", chv(last0, 0), -5000);
        check("negcv ch1", chv(last0, 1), 0);

        // Full-scale CV saturates both rails.
        send(32767, 30000, -30000, 100);
        wait_out("sat");
        check("sat ch1", chv(last0, 1), 32767);
        check("sat ch2", chv(last0, 2), -32768);
        check("sat ch3", chv(last0, 3), 199);

        // Second strobe three cycles in: overrun, ignored, single result from the first frame.
        send(16384, 1234, -4321, 77);
        repeat (2) @(posedge clk);
        #1;
        sin    = {W'(5), W'(6), W'(7), W'(0)};
        strobe = 1'b1;
        @(negedge clk);
        check("overrun dut0", o0, 1'b1);
        check("overrun dut4", o4, 1'b1);
        check("busy at overrun", b0, 1'b1);
        @(posedge clk); #1;
        strobe = 1'b0;
        @(negedge clk);
        check("overrun one cycle", o0, 1'b0);
        wait_out("overrun");
        check("overrun frame ch1", chv(last0, 1), 1234);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (v0 || v4) nv++;
        end
        check("overrun single valid", nv, 0);
        check("idle after frame", b0, 1'b0);

        // Reset mid-frame aborts with no out_valid.
        send(8000, 9000, -9000, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset out dut0", out0, '0);
        check("midreset out dut4", out4, '0);
        check("midreset flags", {v0, b0, v4, b4}, 4'b0);
        q0.delete();
        q4.delete();
        g0 = 0;
        g4 = 0;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (v0 || v4) nv++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (v0 || v4) nv++;
        end
        check("midreset no valid", nv, 0);
        send(16384, 1000, -1000, 0);
        wait_out("postreset");
        check("postreset ch1", chv(last0, 1), 1000);
        check("postreset gain4", chv(last4, 1), 62);

        check("scoreboard drained", q0.size() + q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
